// File: rtl/hub75_bcm_scanner.sv
// HUB75 panel scanner with binary-coded-modulation bit planes.
// Reads {lower, upper} pixel pairs from a 1-cycle-latency frame buffer,
// shifts one bit plane per pass, latches it and holds OE low for
// OE_BASE<<plane cycles. Planes run LSB->MSB, rows ascending.
// Optional macro HUB75_BLANK_EN inserts BLANK_CYCLES dark, clock-idle
// cycles before every latch to suppress ghosting on address change.
// All pin outputs are registered from the current state, so the pin
// waveform trails the state register by one cycle with unchanged durations.
module hub75_bcm_scanner #(
    parameter int NUM_COLS     = 64,
    parameter int SCAN_RATE    = 32,
    parameter int RGB_RES      = 9,
    parameter int OE_BASE      = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          enable,
    output logic [$clog2(SCAN_RATE)+$clog2(NUM_COLS)-1:0] rd_addr,
    output logic                                          rd_en,
    input  logic [2*RGB_RES-1:0]                          rd_data,
    output logic [$clog2(SCAN_RATE)-1:0]                  hub75_addr,
    output logic [2:0]                                    rgb0,
    output logic [2:0]                                    rgb1,
    output logic                                          led_clk,
    output logic                                          led_latch,
    output logic                                          led_output_enable,
    output logic                                          frame_done
);

    localparam int BPC       = RGB_RES / 3;
    localparam int RW        = $clog2(SCAN_RATE);
    localparam int CW        = $clog2(NUM_COLS);
    localparam int PW        = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int IW        = $clog2(RGB_RES);
    localparam int DCW       = $clog2(OE_BASE << (BPC - 1)) + 1;
    localparam int SHIFT_LEN = 2 * NUM_COLS + 1;
    localparam int SCW       = $clog2(SHIFT_LEN + BLANK_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [SCW-1:0]   sc;
    logic [DCW-1:0]   dc;
    logic [DCW-1:0]   disp_len;
    logic [RW-1:0]    row;
    logic [PW-1:0]    plane;
    logic             shift_last;
    logic             disp_last;
    logic             plane_last;
    logic             row_last;

    // Pick bit b of each channel from a {R,G,B} pixel, R in the top BPC bits.
    function automatic logic [2:0] plane_bits(input logic [RGB_RES-1:0] px,
                                              input logic [PW-1:0] b);
        logic [IW-1:0] i;
        i = IW'(b);
        return {px[i + IW'(2 * BPC)], px[i + IW'(BPC)], px[i]};
    endfunction

    assign disp_len   = DCW'(OE_BASE) << plane;
    assign shift_last = (sc == SCW'(SHIFT_LEN - 1));
    assign disp_last  = (dc == disp_len - DCW'(1));
    assign plane_last = (plane == PW'(BPC - 1));
    assign row_last   = (row == RW'(SCAN_RATE - 1));

`ifdef HUB75_BLANK_EN
    logic blank_last;
    assign blank_last = (sc == SCW'(BLANK_CYCLES - 1));
`endif

    // Frame-buffer reads: col c is requested on even shift step 2c so its data
    // is on rd_data during step 2c+1, when the rgb registers capture it.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = {row, sc[CW:1]};
        if (state == SHIFT && !sc[0] && !shift_last) begin
            rd_en = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; enable only matters in IDLE and on the last display cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = SHIFT;
            SHIFT: begin
                if (shift_last) begin
`ifdef HUB75_BLANK_EN
                    next_state = BLANK;
`else
                    next_state = LATCH;
`endif
                end
            end
`ifdef HUB75_BLANK_EN
            BLANK:   if (blank_last) next_state = LATCH;
`endif
            LATCH:   next_state = DISPLAY;
            DISPLAY: if (disp_last) next_state = enable ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Step counter for SHIFT/BLANK, restarted on every state change.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sc <= '0;
        end else if (state != next_state || !(state == SHIFT || state == BLANK)) begin
            sc <= '0;
        end else begin
            sc <= sc + SCW'(1);
        end
    end

    // Display-length counter, runs only inside DISPLAY.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dc <= '0;
        end else if (state == DISPLAY && !disp_last) begin
            dc <= dc + DCW'(1);
        end else begin
            dc <= '0;
        end
    end

    // Plane/row sequencing, advanced when a plane finishes displaying.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            row   <= '0;
            plane <= '0;
        end else if (state == DISPLAY && disp_last) begin
            if (plane_last) begin
                plane <= '0;
                row   <= row_last ? '0 : row + RW'(1);
            end else begin
                plane <= plane + PW'(1);
            end
        end
    end

    // Registered panel pins, decoded from the current state and step.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rgb0              <= '0;
            rgb1              <= '0;
            led_clk           <= 1'b0;
            led_latch         <= 1'b0;
            led_output_enable <= 1'b1;
            hub75_addr        <= '0;
            frame_done        <= 1'b0;
        end else begin
            led_clk           <= 1'b0;
            led_latch         <= 1'b0;
            led_output_enable <= 1'b1;
            frame_done        <= 1'b0;
            case (state)
                SHIFT: begin
                    if (sc[0]) begin
                        rgb0 <= plane_bits(rd_data[RGB_RES-1:0], plane);
                        rgb1 <= plane_bits(rd_data[2*RGB_RES-1:RGB_RES], plane);
                    end else if (sc != '0) begin
                        led_clk <= 1'b1;
                    end
                end
                LATCH: begin
                    led_latch  <= 1'b1;
                    hub75_addr <= row;
                end
                DISPLAY: begin
                    led_output_enable <= 1'b0;
                    if (disp_last && plane_last && row_last) begin
                        frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Directed bench for hub75_bcm_scanner at default parameters.
// A behavioural 1-cycle-latency frame buffer feeds the DUT; outputs are
// sampled on the falling clock edge.
module tb_hub75_bcm_scanner;

    localparam int NUM_COLS  = 64;
    localparam int SCAN_RATE = 32;
    localparam int RGB_RES   = 9;
    localparam int OE_BASE   = 8;
`ifdef HUB75_BLANK_EN
    localparam int GAP   = 4;
    localparam int FRAME = 14656;
`else
    localparam int GAP   = 0;
    localparam int FRAME = 14272;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [10:0] rd_addr;
    logic        rd_en;
    logic [17:0] rd_data = '0;
    logic [4:0]  hub75_addr;
    logic [2:0]  rgb0;
    logic [2:0]  rgb1;
    logic        led_clk;
    logic        led_latch;
    logic        oe;
    logic        frame_done;

    logic [17:0] mem [0:2047];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    hub75_bcm_scanner #(
        .NUM_COLS(NUM_COLS), .SCAN_RATE(SCAN_RATE), .RGB_RES(RGB_RES),
        .OE_BASE(OE_BASE), .BLANK_CYCLES(4)
    ) dut (
        .clk_in(clk), .rst_in(rst), .enable(enable),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .hub75_addr(hub75_addr), .rgb0(rgb0), .rgb1(rgb1),
        .led_clk(led_clk), .led_latch(led_latch),
        .led_output_enable(oe), .frame_done(frame_done)
    );

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL reset_oe: got %b want 1", oe); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++; if (led_clk !== 1'b0 || led_latch !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: clk=%b latch=%b fd=%b want 0", led_clk, led_latch, frame_done);
        end
        checks++; if (rgb0 !== 3'b0 || rgb1 !== 3'b0 || hub75_addr !== 5'd0 || rd_addr !== 11'd0) begin
            errors++; $display("FAIL reset_data: rgb0=%b rgb1=%b addr=%0d rd_addr=%0d want 0", rgb0, rgb1, hub75_addr, rd_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rd_en !== 1'b1 || rd_addr !== 11'd0) begin
            errors++; $display("FAIL first_read: rd_en=%b rd_addr=%0d want 1/0", rd_en, rd_addr);
        end
    endtask

    task automatic test_planes();
        int addr_bad;
        int oe_bad;
        logic [4:0] prev_addr;
        addr_bad = 0;
        oe_bad = 0;
        prev_addr = hub75_addr;
        for (int p = 0; p < 3; p++) begin
            int rises;
            int zeros;
            int low;
            logic prev_clk;
            logic [2:0] r0;
            logic [2:0] r1;
            logic [2:0] exp0;
            rises = 0; zeros = 0; low = 0;
            prev_clk = led_clk;
            r0 = 3'bxxx; r1 = 3'bxxx;
            exp0 = (p == 1) ? 3'b000 : 3'b100;
            for (int n = 0; n < 400; n++) begin
                @(negedge clk);
                if (led_clk && !prev_clk) begin
                    rises++;
                    if (rises == 6) begin r0 = rgb0; r1 = rgb1; end
                end
                prev_clk = led_clk;
                if (led_clk) zeros = 0; else if (!led_latch) zeros++;
                if (hub75_addr !== prev_addr && !led_latch) addr_bad++;
                prev_addr = hub75_addr;
                if (!oe && (led_latch || led_clk)) oe_bad++;
                if (led_latch) break;
            end
            checks++; if (led_latch !== 1'b1) begin errors++; $display("FAIL p%0d_latch: got %b want 1", p, led_latch); end
            checks++; if (rises != NUM_COLS) begin errors++; $display("FAIL p%0d_rises: got %0d want %0d", p, rises, NUM_COLS); end
            checks++; if (r0 !== exp0) begin errors++; $display("FAIL p%0d_rgb0_col5: got %b want %b", p, r0, exp0); end
            checks++; if (r1 !== 3'b000) begin errors++; $display("FAIL p%0d_rgb1_col5: got %b want 000", p, r1); end
            checks++; if (zeros != GAP) begin errors++; $display("FAIL p%0d_blank_gap: got %0d want %0d", p, zeros, GAP); end
            checks++; if (hub75_addr !== 5'd0) begin errors++; $display("FAIL p%0d_row_addr: got %0d want 0", p, hub75_addr); end
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                if (hub75_addr !== prev_addr && !led_latch) addr_bad++;
                prev_addr = hub75_addr;
                if (!oe && (led_latch || led_clk)) oe_bad++;
                if (!oe) low++; else if (low > 0) break;
            end
            checks++; if (low != (OE_BASE << p)) begin errors++; $display("FAIL p%0d_oe_len: got %0d want %0d", p, low, OE_BASE << p); end
        end
        checks++; if (addr_bad != 0) begin errors++; $display("FAIL addr_outside_latch: got %0d want 0", addr_bad); end
        checks++; if (oe_bad != 0) begin errors++; $display("FAIL oe_overlap: got %0d want 0", oe_bad); end
    endtask

    task automatic test_free_run();
        int cyc;
        int latches;
        int lat_bad;
        bit seen;
        seen = 0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (frame_done) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL frame_done_first: got none want pulse"); end
        cyc = 0; latches = 0; lat_bad = 0; seen = 0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            cyc++;
            if (led_latch) begin
                if (hub75_addr !== 5'(latches / 3)) lat_bad++;
                latches++;
            end
            if (frame_done) begin seen = 1; break; end
        end
        checks++; if (!seen || cyc != FRAME) begin errors++; $display("FAIL frame_period: got %0d want %0d", cyc, FRAME); end
        checks++; if (latches != 3 * SCAN_RATE) begin errors++; $display("FAIL frame_latches: got %0d want %0d", latches, 3 * SCAN_RATE); end
        checks++; if (lat_bad != 0) begin errors++; $display("FAIL row_sequence: got %0d bad latches want 0", lat_bad); end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (led_latch) break;
        end
        checks++; if (led_latch !== 1'b1 || hub75_addr !== 5'd0) begin
            errors++; $display("FAIL row_wrap: latch=%b addr=%0d want 1/0", led_latch, hub75_addr);
        end
    endtask

    task automatic test_enable_drop();
        int lat;
        int low;
        int bad;
        bit seen_low;
        lat = 0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (led_latch) lat++;
            if (lat == 9) break;
        end
        checks++; if (lat != 9 || hub75_addr !== 5'd3) begin errors++; $display("FAIL reach_row3: latches=%0d addr=%0d want 9/3", lat, hub75_addr); end
        seen_low = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!oe) seen_low = 1; else if (seen_low) break;
        end
        repeat (30) @(negedge clk);
        enable = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (led_latch) break;
        end
        checks++; if (led_latch !== 1'b1 || hub75_addr !== 5'd3) begin errors++; $display("FAIL drop_latch: latch=%b addr=%0d want 1/3", led_latch, hub75_addr); end
        low = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!oe) low++; else if (low > 0) break;
        end
        checks++; if (low != 16) begin errors++; $display("FAIL drop_oe_len: got %0d want 16", low); end
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (!oe || rd_en || led_clk || led_latch) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
        enable = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rd_en) break;
        end
        checks++; if (rd_en !== 1'b1 || rd_addr !== 11'd192) begin errors++; $display("FAIL resume_read: rd_en=%b rd_addr=%0d want 1/192", rd_en, rd_addr); end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (led_latch) break;
        end
        checks++; if (led_latch !== 1'b1 || hub75_addr !== 5'd3) begin errors++; $display("FAIL resume_latch: latch=%b addr=%0d want 1/3", led_latch, hub75_addr); end
        low = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!oe) low++; else if (low > 0) break;
        end
        checks++; if (low != 32) begin errors++; $display("FAIL resume_oe_len: got %0d want 32", low); end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (led_latch) break;
        end
        checks++; if (led_latch !== 1'b1 || hub75_addr !== 5'd4) begin errors++; $display("FAIL next_row: latch=%b addr=%0d want 1/4", led_latch, hub75_addr); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[5] = {9'b000_000_000, 9'b101_000_000};
        test_reset();
        test_planes();
        test_free_run();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
